// File: rtl/matrix_result_reader.sv
// Captures a 3x3 result matrix written at counter-style indices {row,col},
// then streams it out in row-major order over a valid/ready handshake.
module matrix_result_reader #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          wr_en,
    input  logic [3:0]    wr_idx,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    input  logic          rd_start,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [3:0]    rd_idx,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [8:0]    mask;
    logic [DW-1:0] storage [0:8];

    // Linear slot of a {row,col} index: row*3 + col.
    function automatic logic [3:0] slot_of(input logic [3:0] idx);
        return ({2'b00, idx[3:2]} << 1) + {2'b00, idx[3:2]} + {2'b00, idx[1:0]};
    endfunction

    logic       wr_legal;
    logic [3:0] wr_slot;
    logic       fill_wr;
    logic [8:0] mask_set;
    logic       xfer;

    assign wr_legal = (wr_idx[3:2] != 2'b11) && (wr_idx[1:0] != 2'b11);
    assign wr_slot  = slot_of(wr_idx);
    assign fill_wr  = (state == FILL) && wr_en && wr_legal;
    assign mask_set = mask | (9'd1 << wr_slot);
    assign xfer     = rd_valid && rd_ready;
    assign rd_data  = storage[slot_of(rd_idx)];
    assign rd_last  = (state == DRAIN) && (rd_idx == 4'b1010);

    always_ff @(posedge clk or posedge mr) begin
        if (mr) state <= FILL;
        else    state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_nxt = state;
        full      = 1'b0;
        rd_valid  = 1'b0;
        busy      = 1'b0;
        case (state)
            FILL: begin
                if (fill_wr && (&mask_set)) state_nxt = FULL;
            end
            FULL: begin
                full = 1'b1;
                if (rd_start) state_nxt = DRAIN;
            end
            DRAIN: begin
                rd_valid = 1'b1;
                busy     = 1'b1;
                if (xfer && rd_last) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            mask   <= '0;
            rd_idx <= '0;
            err    <= 1'b0;
            // NOTE: storage is small and must read back as zero after reset, so it is reset explicitly.
            for (int i = 0; i < 9; i++) storage[i] <= '0;
        end else begin
            if (fill_wr) begin
                storage[wr_slot] <= wr_data;
                mask             <= mask_set;
            end

            // A write that lands in the same cycle as an accepted rd_start still flags.
            if ((state == FULL) && rd_start) begin
                err    <= 1'b0;
                rd_idx <= '0;
            end
            if (wr_en && ((state != FILL) || !wr_legal)) err <= 1'b1;

            if (xfer) begin
                if (rd_last) begin
                    rd_idx <= '0;
                    mask   <= '0;
                end else if (rd_idx[1:0] == 2'b10) begin
                    rd_idx <= {rd_idx[3:2] + 2'd1, 2'b00};
                end else begin
                    rd_idx <= {rd_idx[3:2], rd_idx[1:0] + 2'd1};
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_reader.sv
// Scoreboard bench for matrix_result_reader: a reference matrix model queues
// the expected row-major stream at rd_start, and a monitor pops it per transfer.
module tb_matrix_result_reader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          mr;
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_start;
    logic          rd_valid;
    logic          rd_ready;
    logic [3:0]    rd_idx;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          err;

    matrix_result_reader #(.DW(DW)) dut (
        .clk      (clk),
        .mr       (mr),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .full     (full),
        .rd_start (rd_start),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         sb[$];
    logic [DW-1:0] exp_mem [9];
    logic [8:0]    exp_mask;
    logic          exp_err;
    bit            model_fill;
    logic [3:0]    order [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            checks = 0;
    int            failures = 0;
    int            beats = 0;
    int            cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 9; i++) exp_mem[i] = '0;
        exp_mask   = '0;
        exp_err    = 1'b0;
        model_fill = 1'b1;
    endtask

    // All driver tasks enter and leave 1 time unit after a rising edge.
    task automatic reset_dut();
        mr = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_start = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 mr = 1'b0;
        model_clear();
    endtask

    task automatic write(input logic [3:0] idx, input logic [DW-1:0] data);
        int slot;
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
        if (idx[3:2] == 2'b11 || idx[1:0] == 2'b11 || !model_fill) begin
            exp_err = 1'b1;
        end else begin
            slot = int'(idx[3:2]) * 3 + int'(idx[1:0]);
            exp_mem[slot] = data;
            exp_mask[slot] = 1'b1;
            if (&exp_mask) model_fill = 1'b0;
        end
    endtask

    task automatic fill_all(input logic [DW-1:0] base);
        for (int k = 0; k < 9; k++) write(order[k], base + DW'(k));
    endtask

    task automatic start_drain();
        for (int k = 0; k < 9; k++) sb.push_back('{order[k], exp_mem[int'(order[k][3:2]) * 3 + int'(order[k][1:0])]});
        beats = 0;
        rd_start = 1'b1;
        @(posedge clk);
        #1 rd_start = 1'b0;
        exp_err = 1'b0;
        check("start_valid", rd_valid, 1);
        check("start_busy", busy, 1);
        check("start_full", full, 0);
        check("start_idx", rd_idx, 0);
        check("start_err", err, exp_err);
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready follows the 1,0,0,1 pattern.
    task automatic run_drain(input int mode, input int ow_cycle, output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            rd_ready = (mode == 0) ? 1'b1 : pat[cycles % 4];
            if (cycles == ow_cycle) begin
                wr_en = 1'b1; wr_idx = 4'h1; wr_data = 16'hEEEE;
                exp_err = 1'b1;
            end
            @(posedge clk);
            #1 wr_en = 1'b0;
            cycles++;
        end
        rd_ready = 1'b0;
        check("drain_done", busy, 0);
        check("drain_valid", rd_valid, 0);
        check("drain_beats", beats, 9);
        check("drain_sb_left", sb.size(), 0);
        check("drain_idx0", rd_idx, 0);
        exp_mask   = '0;
        model_fill = 1'b1;
    endtask

    // Outputs are sampled on the falling edge; a beat transfers on the next rising edge.
    always @(negedge clk) begin
        if (!mr && rd_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("beat_idx", rd_idx, sb[0].idx);
                check("beat_data", rd_data, sb[0].data);
                check("beat_last", rd_last, sb[0].idx == 4'hA);
                if (rd_ready) begin
                    void'(sb.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        check("rst_full", full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_last", rd_last, 0);
        check("rst_idx", rd_idx, 0);
        check("rst_data", rd_data, 0);

        // In-order fill; rd_start alongside the 9th write must be ignored.
        for (int k = 0; k < 8; k++) write(order[k], DW'(k + 1));
        check("t1_not_full", full, 0);
        rd_start = 1'b1;
        write(order[8], 16'd9);
        rd_start = 1'b0;
        check("t1_full", full, 1);
        check("t1_no_busy", busy, 0);
        start_drain();
        run_drain(0, -1, cyc);
        check("t1_throughput", cyc, 9);
        check("t1_full_after", full, 0);

        // Out-of-order fill with overwrite of slot 0000.
        write(4'hA, 16'h00AA);
        write(4'h0, 16'h0011);
        write(4'h0, 16'h0022);
        for (int k = 1; k < 7; k++) write(order[k], 16'h0050 + DW'(k));
        check("t2_not_full", full, 0);
        write(order[7], 16'h0077);
        check("t2_full", full, 1);
        check("t2_err", err, 0);
        start_drain();
        run_drain(0, -1, cyc);

        // Illegal indices: no store, no mask change, err set until rd_start.
        write(4'hC, 16'hBAD0);
        check("t3_err_c", err, 1);
        for (int k = 0; k < 4; k++) write(order[k], 16'h0100 + DW'(k));
        write(4'h3, 16'hBAD1);
        for (int k = 4; k < 8; k++) write(order[k], 16'h0100 + DW'(k));
        check("t3_not_full", full, 0);
        check("t3_err", err, 1);
        write(order[8], 16'h0108);
        check("t3_full", full, 1);
        check("t3_err_held", err, exp_err);
        start_drain();
        run_drain(0, -1, cyc);

        // Backpressure with rd_ready 1,0,0,1.
        fill_all(16'h0200);
        check("t4_full", full, 1);
        start_drain();
        run_drain(1, -1, cyc);

        // Overrun in FULL and in DRAIN.
        fill_all(16'h0300);
        write(4'h0, 16'hFFFF);
        check("t5_err_full", err, 1);
        check("t5_still_full", full, 1);
        start_drain();
        run_drain(0, 3, cyc);
        check("t5_err_drain", err, exp_err);

        // Reset after beat 4.
        fill_all(16'h0400);
        start_drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && beats < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("t6_beats", beats, 4);
        mr = 1'b1;
        #1;
        check("t6_valid", rd_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_full", full, 0);
        check("t6_idx", rd_idx, 0);
        check("t6_data", rd_data, 0);
        sb.delete();
        rd_ready = 1'b0;
        @(posedge clk);
        #1 mr = 1'b0;
        model_clear();
        fill_all(16'h0500);
        check("t6_refill_full", full, 1);
        start_drain();
        run_drain(0, -1, cyc);
        check("t6_throughput", cyc, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
